// File: rtl/hs_link_rx_fifo.sv
// HS link receive FIFO: FWFT output with a write-to-o_valid latency of 1 cycle; o_ready and o_valid are registered.
// o_ready falls READY_LAT entries before full so in-flight words still land; a word arriving when full with no pop is dropped and counted.
module hs_link_rx_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int READY_LAT = 2,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_fill,
  output logic                   o_overflow,
  output logic [CNT_W-1:0]       o_drop_cnt
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] RDY_LVL  = FILL_W'(DEPTH - READY_LAT);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              valid_q, valid_d;
  logic              ready_q, ready_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              rd, wr, drop;

  // Full/empty come from the occupancy count; pointers simply wrap.
  always_comb begin
    rd       = valid_q & i_ready;
    wr       = i_valid & ((fill_q < FULL_LVL) | rd);
    drop     = i_valid & (fill_q == FULL_LVL) & ~rd;
    wr_ptr_d = wr ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fill_d   = fill_q + FILL_W'(wr) - FILL_W'(rd);
    valid_d  = (fill_d != '0);
    ready_d  = (fill_d < RDY_LVL);
    ovf_d    = ovf_q | drop;
    drop_d   = (drop && !(&drop_q)) ? drop_q + CNT_W'(1) : drop_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign o_data     = mem_q[rd_ptr_q];
  assign o_valid    = valid_q;
  assign o_ready    = ready_q;
  assign o_fill     = fill_q;
  assign o_overflow = ovf_q;
  assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_hs_link_rx_fifo.sv
// Bench for hs_link_rx_fifo: queue-based model checked every cycle plus directed literal checks.
module tb_hs_link_rx_fifo;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int LAT    = 2;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic [4:0]        o_fill;
  logic              o_overflow;
  logic [CNT_W-1:0]  o_drop_cnt;

  always #5 clk = ~clk;

  hs_link_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .READY_LAT(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .o_fill(o_fill),
    .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  logic h1 = 1'b0;
  logic h2 = 1'b0;

  logic [31:0]      mq[$];
  logic             m_rdy = 1'b0;
  logic             m_ovf = 1'b0;
  logic [CNT_W-1:0] m_drop = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Model: a queue of accepted words; drops only when full and nothing leaves.
  always @(posedge clk) begin : model
    int sz;
    bit rd, wr, dr;
    if (!rst_n) begin
      mq.delete();
      m_rdy  <= 1'b0;
      m_ovf  <= 1'b0;
      m_drop <= '0;
    end else begin
      sz = mq.size();
      rd = (sz != 0) && i_ready;
      wr = i_valid && (sz < DEPTH || rd);
      dr = i_valid && !wr;
      if (rd) void'(mq.pop_front());
      if (wr) mq.push_back(i_data);
      m_rdy <= (mq.size() < DEPTH - LAT);
      if (dr) begin
        m_ovf <= 1'b1;
        if (m_drop != {CNT_W{1'b1}}) m_drop <= m_drop + 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("o_valid", o_valid, mq.size() != 0);
      check("o_fill", o_fill, mq.size());
      check("o_ready", o_ready, m_rdy);
      check("o_overflow", o_overflow, m_ovf);
      check("o_drop_cnt", o_drop_cnt, m_drop);
      if (mq.size() != 0) check("o_data", o_data, mq[0]);
    end
  end

  // Remember o_ready of the cycle that is ending, then move to the next negedge.
  task automatic step();
    h2 = h1;
    h1 = o_ready;
    @(negedge clk);
  endtask

  // Compliant upstream: may send while o_ready was seen high within the last LAT cycles.
  task automatic stream(input logic [31:0] base, output int sent, output int fall_at);
    sent = 0;
    fall_at = -1;
    for (int c = 0; c < 24; c++) begin
      step();
      if (!o_ready && fall_at < 0) fall_at = sent;
      if (o_ready || h1 || h2) begin
        i_valid = 1'b1;
        i_data  = base + sent;
        sent++;
      end else begin
        i_valid = 1'b0;
      end
    end
  endtask

  initial begin
    int sent, fall_at, k, rise_fill;
    rst_n = 1'b0; i_valid = 1'b1; i_data = 32'hBAD0; i_ready = 1'b0;
    @(posedge clk);
    chk_en = 1;
    repeat (3) step();
    check("rst_valid", o_valid, 0);
    check("rst_ready", o_ready, 0);
    check("rst_fill", o_fill, 0);
    check("rst_drop", o_drop_cnt, 0);
    rst_n = 1'b1; i_valid = 1'b0;
    step();
    check("rel_ready", o_ready, 1);

    stream(32'h1000, sent, fall_at);
    check("bp_fall_after", fall_at, 14);
    check("bp_accepted", sent, 16);
    check("bp_fill", o_fill, 16);
    check("bp_ovf", o_overflow, 0);
    check("bp_head", o_data, 32'h1000);

    k = 0; rise_fill = -1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 0) i_ready = 1'b1;
      if (o_ready && rise_fill < 0) rise_fill = o_fill;
      if (o_valid) begin
        check("drain_order", o_data, 32'h1000 + k);
        k++;
      end
    end
    check("drain_count", k, 16);
    check("drain_rdy_fill", rise_fill, 13);
    check("drain_empty", o_valid, 0);

    i_ready = 1'b0;
    stream(32'h3000, sent, fall_at);
    check("refill_sent", sent, 16);
    step();
    i_valid = 1'b1; i_data = 32'hDEAD;
    step();
    step();
    i_valid = 1'b0;
    check("ovf_flag", o_overflow, 1);
    check("ovf_cnt", o_drop_cnt, 2);
    check("ovf_head", o_data, 32'h3000);
    check("ovf_fill", o_fill, 16);

    i_ready = 1'b1; i_valid = 1'b1; i_data = 32'h4000;
    step();
    i_ready = 1'b0; i_valid = 1'b0;
    check("simul_fill", o_fill, 16);
    check("simul_drop", o_drop_cnt, 2);
    check("simul_head", o_data, 32'h3001);

    sent = 0;
    for (int c = 0; c < 6000 && sent < 1000; c++) begin
      step();
      if ((o_ready || h1 || h2) && $urandom_range(0, 3) != 0) begin
        i_valid = 1'b1;
        i_data  = 32'h5000_0000 + sent;
        sent++;
      end else begin
        i_valid = 1'b0;
      end
      i_ready = ($urandom_range(0, 2) != 0);
    end
    check("rand_sent", sent, 1000);
    step();
    i_valid = 1'b0; i_ready = 1'b1;
    for (int c = 0; c < 40 && o_fill != 0; c++) step();
    check("rand_drained", o_fill, 0);
    check("rand_nodrop", o_drop_cnt, 2);

    i_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      i_valid = 1'b1;
      i_data  = 32'h6000 + c;
    end
    step();
    i_valid = 1'b0;
    check("mid_fill5", o_fill, 5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mid_rst_fill", o_fill, 0);
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_drop", o_drop_cnt, 0);
    step();
    check("mid_rel_ready", o_ready, 1);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
